// File: rtl/me_sprite_fetch.sv
// Sprite fetch stage: scan position + latched sprite position -> sprite-ROM address,
// 3-cycle pipeline to palette index, and vsync-paced walk-animation sequencer. Optional: SPRITE_FLIP_EN.
module me_sprite_fetch #(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int FRAMES      = 4,
  parameter int FRAME_TICKS = 8,
  parameter int ADDR_W      = 12,
  parameter int TRANSP_IDX  = 1,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              pix_valid,
  input  logic              vsync,
  input  logic [9:0]        SpriteX,
  input  logic [9:0]        SpriteY,
  input  logic              moving,
  input  logic              facing_left,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        pal_index,
  output logic              sprite_on,
  output logic [FW-1:0]     frame_idx
);

  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [31:0] FRAME_SZ = 32'(SPR_W * SPR_H);
  localparam logic [31:0] SPR_W32  = 32'(SPR_W);
  localparam logic [3:0]  TRANSP   = 4'(TRANSP_IDX);

  typedef enum logic {IDLE, RUN} state_t;

  logic        vs_q;
  logic        vs_fall;
  logic [9:0]  sx, sy;
  logic        flip;

  assign vs_fall = vs_q & ~vsync;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_q <= 1'b1;
      sx   <= '0;
      sy   <= '0;
    end else begin
      vs_q <= vsync;
      if (vs_fall) begin
        sx <= SpriteX;
        sy <= SpriteY;
      end
    end
  end

`ifdef SPRITE_FLIP_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)     flip <= 1'b0;
    else if (vs_fall) flip <= facing_left;
  end
`else
  logic unused_facing;
  assign unused_facing = facing_left;
  assign flip          = 1'b0;
`endif

  // Stage 0: hit test at 11 bits so a sprite near column 1023 never wraps
  logic [10:0]       x_end, y_end;
  logic [9:0]        dx, dy;
  logic [31:0]       lx;
  logic              hit_p0;
  logic [ADDR_W-1:0] addr_p0;

  assign x_end  = {1'b0, sx} + 11'(SPR_W);
  assign y_end  = {1'b0, sy} + 11'(SPR_H);
  assign hit_p0 = pix_valid && (DrawX >= sx) && ({1'b0, DrawX} < x_end)
                            && (DrawY >= sy) && ({1'b0, DrawY} < y_end);
  assign dx     = DrawX - sx;
  assign dy     = DrawY - sy;
  assign lx     = flip ? (SPR_W32 - 32'd1 - 32'(dx)) : 32'(dx);
  assign addr_p0 = hit_p0 ? ADDR_W'(32'(frame_idx) * FRAME_SZ + 32'(dy) * SPR_W32 + lx)
                          : '0;

  // Stages 1-3: address out, ROM access, palette index out
  logic vld_p1, vld_p2;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      pal_index <= '0;
      sprite_on <= 1'b0;
    end else begin
      rom_addr  <= addr_p0;
      vld_p1    <= hit_p0;
      vld_p2    <= vld_p1;
      pal_index <= rom_data;
      sprite_on <= vld_p2 && (rom_data != TRANSP);
    end
  end

  // Animation sequencer
  state_t         state_q, state_d;
  logic [TW-1:0]  tick_q, tick_d;
  logic [FW-1:0]  frame_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      frame_idx <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      frame_idx <= frame_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (vs_fall) state_d = moving ? RUN : IDLE;
  end

  // IDLE holds tick/frame at zero, so the entering pulse counts as the first tick
  always_comb begin
    tick_d  = tick_q;
    frame_d = frame_idx;
    if (vs_fall) begin
      if (moving) begin
        if (32'(tick_q) == 32'(FRAME_TICKS - 1)) begin
          tick_d  = '0;
          frame_d = (32'(frame_idx) == 32'(FRAMES - 1)) ? '0 : frame_idx + FW'(1);
        end else begin
          tick_d  = tick_q + TW'(1);
        end
      end else begin
        tick_d  = '0;
        frame_d = '0;
      end
    end
  end

endmodule

// File: tb/tb_me_sprite_fetch.sv
// Directed bench for me_sprite_fetch with a queue scoreboard of expected addresses and pixels.
module tb_me_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
  logic        pix_valid, vsync, moving, facing_left;
  logic [11:0] rom_addr;
  logic [3:0]  rom_data = 4'd0;
  logic [3:0]  pal_index;
  logic        sprite_on;
  logic [1:0]  frame_idx;

  me_sprite_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .pix_valid(pix_valid), .vsync(vsync), .SpriteX(SpriteX), .SpriteY(SpriteY),
    .moving(moving), .facing_left(facing_left), .rom_addr(rom_addr),
    .rom_data(rom_data), .pal_index(pal_index), .sprite_on(sprite_on),
    .frame_idx(frame_idx)
  );

  always #5 Clk = ~Clk;

  logic [3:0] mem [0:4095];
  always @(posedge Clk) rom_data <= mem[rom_addr];

  typedef struct {
    int          due;
    logic [31:0] val;
    logic        on;
  } ent_t;

  ent_t qa[$];
  ent_t qp[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference state
  int sh_x = 0, sh_y = 0, m_frame = 0, m_tick = 0;
  bit sh_f = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model(input int x, input int y, input bit v, output int a, output bit h);
    int lx;
    h = v && x >= sh_x && x < sh_x + 32 && y >= sh_y && y < sh_y + 32;
    a = 0;
    if (h) begin
      lx = x - sh_x;
`ifdef SPRITE_FLIP_EN
      if (sh_f) lx = 31 - lx;
`endif
      a = (m_frame * 1024 + (y - sh_y) * 32 + lx) % 4096;
    end
  endtask

  task automatic tick();
    int a;
    bit h;
    ent_t e;
    if (Reset_n) begin
      model(int'(DrawX), int'(DrawY), pix_valid, a, h);
      qa.push_back('{cyc + 1, 32'(a), 1'b0});
      qp.push_back('{cyc + 3, 32'(mem[a]), h && (mem[a] != 4'd1)});
    end
    @(posedge Clk);
    cyc++;
    #1;
    while (qa.size() > 0 && qa[0].due == cyc) begin
      e = qa.pop_front();
      chk("sb_rom_addr", 32'(rom_addr), e.val);
    end
    while (qp.size() > 0 && qp[0].due == cyc) begin
      e = qp.pop_front();
      chk("sb_pal_index", 32'(pal_index), e.val);
      chk("sb_sprite_on", 32'(sprite_on), 32'(e.on));
    end
  endtask

  task automatic vpulse();
    pix_valid = 1'b0;
    vsync     = 1'b0;
    sh_x = int'(SpriteX);
    sh_y = int'(SpriteY);
    sh_f = facing_left;
    if (moving) begin
      m_tick++;
      if (m_tick == 8) begin
        m_tick  = 0;
        m_frame = (m_frame + 1) % 4;
      end
    end else begin
      m_tick  = 0;
      m_frame = 0;
    end
    tick();
    vsync = 1'b1;
    tick();
  endtask

  task automatic model_reset();
    sh_x = 0; sh_y = 0; sh_f = 0; m_frame = 0; m_tick = 0;
  endtask

  task automatic pix(input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y); pix_valid = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 4'((i * 5 + 2) % 16);
    mem[0]  = 4'd0;
    mem[69] = 4'd3;
    Reset_n = 1'b1; DrawX = '0; DrawY = '0; pix_valid = 1'b0; vsync = 1'b1;
    SpriteX = '0; SpriteY = '0; moving = 1'b0; facing_left = 1'b0;

    // reset state
    #3 Reset_n = 1'b0;
    #1;
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_pal_index", 32'(pal_index), 0);
    chk("rst_sprite_on", 32'(sprite_on), 0);
    chk("rst_frame_idx", 32'(frame_idx), 0);
    repeat (3) tick();
    Reset_n = 1'b1;
    model_reset();
    repeat (3) tick();
    chk("idle_rom_addr", 32'(rom_addr), 0);
    chk("idle_pal_index", 32'(pal_index), 0);
    chk("idle_sprite_on", 32'(sprite_on), 0);

    // basic hit, frame 0
    SpriteX = 10'd100; SpriteY = 10'd50;
    vpulse();
    pix(105, 52);
    tick();
    chk("hit_rom_addr", 32'(rom_addr), 69);
    pix_valid = 1'b0;
    tick();
    chk("hit_on_early", 32'(sprite_on), 0);
    tick();
    chk("hit_pal_index", 32'(pal_index), 3);
    chk("hit_sprite_on", 32'(sprite_on), 1);

    // transparent index and right edge
    repeat (3) tick();
    mem[69] = 4'd1;
    pix(105, 52);
    tick(); pix_valid = 1'b0; tick(); tick();
    chk("transp_pal_index", 32'(pal_index), 1);
    chk("transp_sprite_on", 32'(sprite_on), 0);
    pix(132, 52); tick();
    pix(131, 52); tick();
    pix_valid = 1'b0; tick();
    chk("edge132_on", 32'(sprite_on), 0);
    tick();
    chk("edge131_on", 32'(sprite_on), 1);
    chk("edge131_pal", 32'(pal_index), 13);
    repeat (2) tick();

    // flip latched at vsync; mid-frame toggle has no effect
    facing_left = 1'b1;
    vpulse();
    pix(105, 52); tick();
`ifdef SPRITE_FLIP_EN
    chk("flip_rom_addr", 32'(rom_addr), 90);
`else
    chk("flip_rom_addr", 32'(rom_addr), 69);
`endif
    facing_left = 1'b0;
    pix(105, 52); tick();
`ifdef SPRITE_FLIP_EN
    chk("flip_hold_addr", 32'(rom_addr), 90);
`else
    chk("flip_hold_addr", 32'(rom_addr), 69);
`endif
    vpulse();
    pix(105, 52); tick();
    chk("unflip_rom_addr", 32'(rom_addr), 69);
    pix_valid = 1'b0;
    repeat (3) tick();

    // animation sequence
    moving = 1'b1;
    for (int n = 1; n <= 32; n++) begin
      vpulse();
      chk("anim_frame_idx", 32'(frame_idx), 32'((n / 8) % 4));
      if (n == 16) begin
        pix(100, 50); tick();
        chk("frame2_rom_addr", 32'(rom_addr), 2048);
        pix_valid = 1'b0;
      end
    end
    repeat (8) vpulse();
    chk("anim_frame1", 32'(frame_idx), 1);

    // right screen edge, no wrap
    SpriteX = 10'd1000; SpriteY = 10'd50;
    vpulse();
    pix(1023, 60); tick();
    chk("nowrap_rom_addr", 32'(rom_addr), 1367);
    pix(999, 60); tick();
    chk("left_miss_addr", 32'(rom_addr), 0);
    pix_valid = 1'b0;
    repeat (3) tick();

    // drop moving mid-animation
    moving = 1'b0;
    vpulse();
    chk("stop_frame_idx", 32'(frame_idx), 0);
    moving = 1'b1;
    repeat (8) vpulse();
    chk("restart_frame1", 32'(frame_idx), 1);

    // async reset mid-line
    pix(1010, 55); tick();
    pix(1011, 55); tick();
    #2 Reset_n = 1'b0;
    #1;
    chk("midrst_rom_addr", 32'(rom_addr), 0);
    chk("midrst_pal_index", 32'(pal_index), 0);
    chk("midrst_sprite_on", 32'(sprite_on), 0);
    chk("midrst_frame_idx", 32'(frame_idx), 0);
    qa.delete();
    qp.delete();
    model_reset();
    pix_valid = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    pix(5, 3); tick();
    chk("post_rst_addr", 32'(rom_addr), 101);
    pix_valid = 1'b0; tick();
    chk("post_rst_on_hold", 32'(sprite_on), 0);
    tick();
    chk("post_rst_on", 32'(sprite_on), 1);
    chk("post_rst_pal", 32'(pal_index), 11);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
